// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file write-back queue.
package wb_pkg;

    localparam int unsigned REG_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 16;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] onehot16(input logic [REG_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wbq_storage.sv
// Circular buffer of write-back entries: up to two pushes (a before b) and one pop per cycle.
// Entries and valid flags are presented in age order, index 0 being the head.
module wbq_storage
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_a,
    input  wb_entry_t              entry_a,
    input  logic                   push_b,
    input  wb_entry_t              entry_b,
    input  logic                   pop,
    output wb_entry_t              entries [DEPTH],
    output logic [DEPTH-1:0]       valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push_a) + PW'(push_b);
            count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_a) mem[tail] <= entry_a;
        if (push_b) mem[tail + PW'(push_a)] <= entry_b;
    end

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            entries[k] = mem[head + PW'(k)];
            valid[k]   = CW'(k) < count;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side front end of the 16x16 register file: merges ALU and load results into one write port.
// Optional macro WBQ_FWD_EN adds a youngest-match forwarding lookup (fwd_reg/fwd_hit/fwd_data).
module regfile_wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_W-1:0]       alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_W-1:0]       mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   wb_hold,
    output logic [REG_W-1:0]       DstReg,
    output logic [DATA_W-1:0]      DstData,
    output logic                   WriteReg,
    output logic [NUM_REGS-1:0]    pending,
`ifdef WBQ_FWD_EN
    input  logic [REG_W-1:0]       fwd_reg,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    wb_entry_t        mem_entry;
    wb_entry_t        alu_entry;
    logic             mem_fire;
    logic             alu_fire;

    assign mem_entry = '{dst: mem_reg, data: mem_data};
    assign alu_entry = '{dst: alu_reg, data: alu_data};

    // Load results take the first free slot; ALU gets the slot only if one remains after it.
    always_comb begin
        mem_ready = count < CW'(DEPTH);
        alu_ready = (count < CW'(DEPTH - 1)) || (mem_ready && !mem_valid);
        mem_fire  = mem_valid && mem_ready;
        alu_fire  = alu_valid && alu_ready;
    end

    wbq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .rst     (rst),
        .push_a  (mem_fire),
        .entry_a (mem_entry),
        .push_b  (alu_fire),
        .entry_b (alu_entry),
        .pop     (WriteReg),
        .entries (entries),
        .valid   (valid),
        .count   (count)
    );

    always_comb begin
        WriteReg = valid[0] && !wb_hold;
        DstReg   = '0;
        DstData  = '0;
        if (valid[0]) begin
            DstReg  = entries[0].dst;
            DstData = entries[0].data;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid[k]) pending = pending | onehot16(entries[k].dst);
        end
    end

`ifdef WBQ_FWD_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid[k] && entries[k].dst == fwd_reg) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[k].data;
            end
        end
    end
`endif

endmodule
